// File: rtl/cycle_pe_mem_arbiter.sv
// cycle_pe_mem_arbiter
//   Shares one in-order memory read port among NUM_PE cycle-detection PEs.
//   PE address-FIFO heads are arbitrated round-robin. Each accepted request
//   pushes its requester ID into a circular tag FIFO. In-order responses pop
//   that FIFO and return to the owning PE one cycle later as a data-valid pulse.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   pe_addr        NUM_PE packed 64-bit read addresses, PE i at [64i+63:64i]
//   pe_addr_val    per-PE address FIFO non-empty
//   pe_pop         one-hot pop strobe to the granted PE (same cycle as accept)
//   pe_din         response data shared by all PEs
//   pe_din_val     one-hot, marks the PE that owns pe_din this cycle
//   mem_req_addr   memory read address (0 when no request)
//   mem_req_val    memory request valid
//   mem_req_rdy    memory can accept a request
//   mem_rsp_data   memory read data, returned in request order
//   mem_rsp_val    memory response valid (cannot be stalled)
//   outstanding    reads issued but not yet answered
//   err_spurious   sticky: a response arrived with nothing outstanding
module cycle_pe_mem_arbiter #(
   parameter int NUM_PE     = 4,
   parameter int OUTST_LOG2 = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [64*NUM_PE-1:0]     pe_addr,
   input  logic [NUM_PE-1:0]        pe_addr_val,
   output logic [NUM_PE-1:0]        pe_pop,
   output logic [63:0]              pe_din,
   output logic [NUM_PE-1:0]        pe_din_val,
   output logic [63:0]              mem_req_addr,
   output logic                     mem_req_val,
   input  logic                     mem_req_rdy,
   input  logic [63:0]              mem_rsp_data,
   input  logic                     mem_rsp_val,
   output logic [OUTST_LOG2:0]      outstanding,
   output logic                     err_spurious
);

   localparam int ID_W  = $clog2(NUM_PE);
   localparam int DEPTH = 1 << OUTST_LOG2;
   localparam logic [OUTST_LOG2:0] FULL_CNT = (OUTST_LOG2+1)'(DEPTH);

   logic [63:0]             addr_arr [NUM_PE];
   logic [ID_W-1:0]         rr;
   logic [ID_W-1:0]         grant;
   logic [63:0]             grant_addr;
   logic                    any_val;
   logic                    tag_full;
   logic                    accept;
   logic                    rsp_ok;
   logic [ID_W-1:0]         head_id;
   logic [ID_W-1:0]         tag_mem [DEPTH];
   logic [OUTST_LOG2-1:0]   wr_ptr;
   logic [OUTST_LOG2-1:0]   rd_ptr;
   logic [OUTST_LOG2:0]     cnt_p1;
   logic [63:0]             din_p1;
   logic [NUM_PE-1:0]       vld_p1;
   logic                    err_p1;

   function automatic logic [NUM_PE-1:0] id_onehot(input logic [ID_W-1:0] id);
      return NUM_PE'(1) << id;
   endfunction

   for (genvar i = 0; i < NUM_PE; i++) begin : g_addr
      assign addr_arr[i] = pe_addr[64*i +: 64];
   end

   // ---- stage p0: combinational round-robin arbitration and request ----
   always_comb begin : arb
      logic [ID_W-1:0] idx;
      logic            found;
      grant      = '0;
      grant_addr = '0;
      found      = 1'b0;
      idx        = '0;
      // Scan starting at rr; the first valid PE wins.
      for (int k = 0; k < NUM_PE; k++) begin
         idx = ID_W'((int'(rr) + k) % NUM_PE);
         if (!found && pe_addr_val[idx]) begin
            found      = 1'b1;
            grant      = idx;
            grant_addr = addr_arr[idx];
         end
      end
   end

   assign any_val  = |pe_addr_val;
   // Full is judged on the registered count only: a response landing this
   // cycle does not free a slot until next cycle.
   assign tag_full = (cnt_p1 == FULL_CNT);
   assign mem_req_val  = any_val & ~tag_full & ~rst;
   assign mem_req_addr = mem_req_val ? grant_addr : 64'd0;
   assign accept       = mem_req_val & mem_req_rdy;
   assign pe_pop       = accept ? id_onehot(grant) : '0;

   assign rsp_ok  = mem_rsp_val & (cnt_p1 != '0);
   assign head_id = tag_mem[rd_ptr];

   // Tag storage holds data only; pointers and count define its validity.
   always_ff @(posedge clk) begin
      if (accept) tag_mem[wr_ptr] <= grant;
   end

   // ---- stage p1: tag FIFO control, response steering, outstanding count ----
   always_ff @(posedge clk) begin
      if (rst) begin
         rr     <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_p1 <= '0;
         din_p1 <= '0;
         vld_p1 <= '0;
         err_p1 <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + OUTST_LOG2'(1);
            rr     <= (grant == ID_W'(NUM_PE-1)) ? '0 : grant + ID_W'(1);
         end
         if (rsp_ok) begin
            rd_ptr <= rd_ptr + OUTST_LOG2'(1);
            din_p1 <= mem_rsp_data;
            vld_p1 <= id_onehot(head_id);
         end else begin
            vld_p1 <= '0;
         end
         if (mem_rsp_val && !rsp_ok) err_p1 <= 1'b1;
         case ({accept, rsp_ok})
            2'b10:   cnt_p1 <= cnt_p1 + (OUTST_LOG2+1)'(1);
            2'b01:   cnt_p1 <= cnt_p1 - (OUTST_LOG2+1)'(1);
            default: cnt_p1 <= cnt_p1;
         endcase
      end
   end

   assign pe_din       = din_p1;
   assign pe_din_val   = vld_p1;
   assign outstanding  = cnt_p1;
   assign err_spurious = err_p1;

endmodule

// File: tb/tb_cycle_pe_mem_arbiter.sv
// tb_cycle_pe_mem_arbiter
//   Directed scenarios followed by randomized traffic for cycle_pe_mem_arbiter.
//   The reference model keeps a queue of requester IDs in issue order, a
//   round-robin start index, and the expected response registers.
module tb_cycle_pe_mem_arbiter;

   localparam int NUM_PE     = 4;
   localparam int OUTST_LOG2 = 3;
   localparam int DEPTH      = 1 << OUTST_LOG2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [64*NUM_PE-1:0]   pe_addr;
   logic [NUM_PE-1:0]      pe_addr_val;
   logic [NUM_PE-1:0]      pe_pop;
   logic [63:0]            pe_din;
   logic [NUM_PE-1:0]      pe_din_val;
   logic [63:0]            mem_req_addr;
   logic                   mem_req_val;
   logic                   mem_req_rdy;
   logic [63:0]            mem_rsp_data;
   logic                   mem_rsp_val;
   logic [OUTST_LOG2:0]    outstanding;
   logic                   err_spurious;

   logic [63:0]            addr [NUM_PE];

   int                     n_cmp = 0;
   int                     n_bad = 0;

   // reference model state
   int                     m_rr;
   int                     tagq[$];
   int                     grants[$];
   logic [NUM_PE-1:0]      exp_dv;
   logic [63:0]            exp_din;
   logic                   exp_err;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NUM_PE; i++) pe_addr[i*64 +: 64] = addr[i];
   end

   cycle_pe_mem_arbiter #(.NUM_PE(NUM_PE), .OUTST_LOG2(OUTST_LOG2)) dut (
      .clk          (clk),
      .rst          (rst),
      .pe_addr      (pe_addr),
      .pe_addr_val  (pe_addr_val),
      .pe_pop       (pe_pop),
      .pe_din       (pe_din),
      .pe_din_val   (pe_din_val),
      .mem_req_addr (mem_req_addr),
      .mem_req_val  (mem_req_val),
      .mem_req_rdy  (mem_req_rdy),
      .mem_rsp_data (mem_rsp_data),
      .mem_rsp_val  (mem_rsp_val),
      .outstanding  (outstanding),
      .err_spurious (err_spurious)
   );

   initial begin
      #200us;
      $display("FAIL timeout: observed no finish, expected finish within 200us");
      $fatal(1, "bench timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of traffic: drive at negedge, check request side before the
   // edge, advance the model, check registered outputs after the edge.
   task automatic cycle(input logic [NUM_PE-1:0] val, input logic rdy,
                        input logic rsp, input logic [63:0] rdata,
                        output int g, output bit acc);
      int          sz;
      int          id;
      bit          mval;
      logic [63:0] ea;
      @(negedge clk);
      pe_addr_val  = val;
      mem_req_rdy  = rdy;
      mem_rsp_val  = rsp;
      mem_rsp_data = rdata;
      #1;
      g = -1;
      for (int k = 0; k < NUM_PE; k++)
         if (g < 0 && val[(m_rr + k) % NUM_PE]) g = (m_rr + k) % NUM_PE;
      sz   = tagq.size();
      mval = (g >= 0) && (sz < DEPTH);
      acc  = mval && rdy;
      ea   = 64'd0;
      if (mval) ea = addr[g];
      chk("mem_req_val", 64'(mem_req_val), 64'(mval));
      chk("mem_req_addr", mem_req_addr, ea);
      chk("pe_pop", 64'(pe_pop), acc ? (64'd1 << g) : 64'd0);
      exp_dv = '0;
      if (rsp) begin
         if (sz > 0) begin
            id      = tagq.pop_front();
            exp_dv  = NUM_PE'(1) << id;
            exp_din = rdata;
         end else begin
            exp_err = 1'b1;
         end
      end
      if (acc) begin
         tagq.push_back(g);
         grants.push_back(g);
         m_rr = (g + 1) % NUM_PE;
      end
      @(posedge clk);
      #1;
      chk("outstanding", 64'(outstanding), 64'(tagq.size()));
      chk("pe_din_val", 64'(pe_din_val), 64'(exp_dv));
      chk("pe_din", pe_din, exp_din);
      chk("err_spurious", 64'(err_spurious), 64'(exp_err));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst          = 1'b1;
      pe_addr_val  = '0;
      mem_req_rdy  = 1'b0;
      mem_rsp_val  = 1'b0;
      mem_rsp_data = '0;
      @(posedge clk);
      #1;
      chk("rst_outstanding", 64'(outstanding), 64'd0);
      chk("rst_pe_din_val", 64'(pe_din_val), 64'd0);
      chk("rst_pe_din", pe_din, 64'd0);
      chk("rst_err", 64'(err_spurious), 64'd0);
      chk("rst_mem_req_val", 64'(mem_req_val), 64'd0);
      chk("rst_pe_pop", 64'(pe_pop), 64'd0);
      chk("rst_mem_req_addr", mem_req_addr, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tagq.delete();
      m_rr    = 0;
      exp_dv  = '0;
      exp_din = '0;
      exp_err = 1'b0;
   endtask

   initial begin
      int                g;
      bit                acc;
      int                cnt;
      int                pend [NUM_PE];
      logic [NUM_PE-1:0] val;
      logic              rdy;
      logic              rsp;

      rst          = 1'b1;
      pe_addr_val  = '0;
      mem_req_rdy  = 1'b0;
      mem_rsp_val  = 1'b0;
      mem_rsp_data = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         addr[i] = '0;
         pend[i] = 0;
      end
      do_reset();

      // single requester
      addr[2] = 64'h100;
      cycle(4'b0100, 1'b1, 1'b0, 64'd0, g, acc);
      chk("t1_out1", 64'(outstanding), 64'd1);
      cycle(4'b0000, 1'b1, 1'b0, 64'd0, g, acc);
      cycle(4'b0000, 1'b1, 1'b0, 64'd0, g, acc);
      cycle(4'b0000, 1'b1, 1'b1, 64'h200, g, acc);
      chk("t1_din", pe_din, 64'h200);
      chk("t1_dv", 64'(pe_din_val), 64'b0100);
      chk("t1_out0", 64'(outstanding), 64'd0);

      // round-robin fairness, then fill to full
      do_reset();
      grants.delete();
      for (int i = 0; i < NUM_PE; i++) addr[i] = 64'h1000 + 64'(i);
      repeat (8) cycle(4'b1111, 1'b1, 1'b0, 64'd0, g, acc);
      chk("t2_ngrants", 64'(grants.size()), 64'd8);
      for (int k = 0; k < 8 && k < grants.size(); k++)
         chk("t2_order", 64'(grants[k]), 64'(k % NUM_PE));
      for (int p = 0; p < NUM_PE; p++) begin
         cnt = 0;
         foreach (grants[k]) if (grants[k] == p) cnt++;
         chk("t2_per_pe", 64'(cnt), 64'd2);
      end
      chk("t4_out8", 64'(outstanding), 64'd8);
      cycle(4'b1111, 1'b1, 1'b0, 64'd0, g, acc);
      chk("t4_blocked", 64'(mem_req_val), 64'd0);
      cycle(4'b1111, 1'b1, 1'b1, 64'hD0, g, acc);
      chk("t4_out7", 64'(outstanding), 64'd7);
      chk("t4_reissue_val", 64'(mem_req_val), 64'd1);
      cycle(4'b1111, 1'b1, 1'b0, 64'd0, g, acc);
      chk("t4_out8b", 64'(outstanding), 64'd8);
      repeat (8) cycle(4'b0000, 1'b0, 1'b1, {$urandom, $urandom}, g, acc);

      // backpressure on PE1
      addr[1] = 64'hBEEF;
      repeat (5) cycle(4'b0010, 1'b0, 1'b0, 64'd0, g, acc);
      chk("t3_no_out", 64'(outstanding), 64'd0);
      cycle(4'b0010, 1'b1, 1'b0, 64'd0, g, acc);
      chk("t3_one", 64'(outstanding), 64'd1);
      cycle(4'b0000, 1'b0, 1'b1, 64'h1234, g, acc);
      chk("t3_dv", 64'(pe_din_val), 64'b0010);

      // simultaneous accept and response at outstanding = 3
      do_reset();
      cycle(4'b0001, 1'b1, 1'b0, 64'd0, g, acc);
      cycle(4'b0010, 1'b1, 1'b0, 64'd0, g, acc);
      cycle(4'b0100, 1'b1, 1'b0, 64'd0, g, acc);
      cycle(4'b1000, 1'b1, 1'b1, 64'hABC, g, acc);
      chk("t5_out3", 64'(outstanding), 64'd3);
      chk("t5_dv_head", 64'(pe_din_val), 64'b0001);
      chk("t5_din", pe_din, 64'hABC);
      repeat (3) cycle(4'b0000, 1'b0, 1'b1, {$urandom, $urandom}, g, acc);

      // spurious response, then reset with reads in flight
      cycle(4'b0000, 1'b0, 1'b1, 64'h55, g, acc);
      chk("t6_err", 64'(err_spurious), 64'd1);
      chk("t6_no_dv", 64'(pe_din_val), 64'd0);
      chk("t6_out0", 64'(outstanding), 64'd0);
      repeat (3) cycle(4'b0000, 1'b0, 1'b0, 64'd0, g, acc);
      chk("t6_err_held", 64'(err_spurious), 64'd1);
      repeat (4) cycle(4'b1111, 1'b1, 1'b0, 64'd0, g, acc);
      chk("t6_out4", 64'(outstanding), 64'd4);
      do_reset();

      // randomized traffic; a PE keeps its valid until popped
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NUM_PE; i++) begin
            if (pend[i] < 3 && $urandom_range(0, 3) == 0) pend[i]++;
            val[i] = (pend[i] > 0);
         end
         rdy = ($urandom_range(0, 3) != 0);
         rsp = (tagq.size() > 0) && ($urandom_range(0, 1) == 1);
         cycle(val, rdy, rsp, {$urandom, $urandom}, g, acc);
         if (acc) begin
            pend[g]--;
            addr[g] = ($urandom_range(0, 7) == 0) ? 64'd0 : {$urandom, $urandom};
         end
      end
      while (tagq.size() > 0) cycle(4'b0000, 1'b0, 1'b1, {$urandom, $urandom}, g, acc);
      chk("end_out0", 64'(outstanding), 64'd0);
      chk("end_err", 64'(err_spurious), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
